// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq_pkg : shared types and constants for the ALU program sequencer|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DECODE = 2'd2,
      ST_EXEC   = 2'd3
   } state_t;

   localparam int INSTR_W  = 14;
   localparam int REG_W    = 6;
   localparam int NUM_REGS = 4;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_SHF  = 3'd2;
   localparam logic [2:0] OP_AND  = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_BR   = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   localparam int OP_MSB   = 13;
   localparam int OP_LSB   = 11;
   localparam int IMM_BIT  = 10;
   localparam int RD_MSB   = 9;
   localparam int RD_LSB   = 8;
   localparam int RS_MSB   = 7;
   localparam int RS_LSB   = 6;
   localparam int MASK_MSB = 9;
   localparam int MASK_LSB = 6;
   localparam int DATA_MSB = 5;
   localparam int RS2_MSB  = 1;

   localparam int FLG_N = 0;
   localparam int FLG_P = 1;
   localparam int FLG_Z = 2;
   localparam int FLG_O = 3;

endpackage
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq_regfile : 4x6 register file, two operand reads, debug read   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_seq_regfile
   import alu_seq_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   input  logic [1:0]       i_waddr,
   input  logic [REG_W-1:0] i_wdata,
   input  logic [1:0]       i_raddr0,
   input  logic [1:0]       i_raddr1,
   input  logic [1:0]       i_raddr2,
   output logic [REG_W-1:0] o_rdata0,
   output logic [REG_W-1:0] o_rdata1,
   output logic [REG_W-1:0] o_rdata2
);

   logic [REG_W-1:0] regs_q [NUM_REGS];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (i_we) begin
         regs_q[i_waddr] <= i_wdata;
      end
   end

   // Reads see the pre-write contents when a write lands in the same cycle.
   assign o_rdata0 = regs_q[i_raddr0];
   assign o_rdata1 = regs_q[i_raddr1];
   assign o_rdata2 = regs_q[i_raddr2];

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq_ctrl : fetch/decode/execute sequencer driving the 6-bit ALU  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int PC_W      = 6,
   parameter int MAX_STEPS = 63
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error,
   output logic [PC_W-1:0]    o_pc,
   input  logic [INSTR_W-1:0] i_instr,
   output logic [REG_W-1:0]   o_arg0,
   output logic [REG_W-1:0]   o_arg1,
   output logic [2:0]         o_oper,
   output logic [REG_W-1:0]   o_data,
   output logic               o_imm,
   input  logic [REG_W-1:0]   i_result,
   input  logic [3:0]         i_flag,
   input  logic [1:0]         i_rsel,
   output logic [REG_W-1:0]   o_rdata,
   output logic [3:0]         o_flags
);

   localparam int STEP_W = $clog2(MAX_STEPS + 1);

   state_t               state_q;
   logic [PC_W-1:0]      pc_q;
   logic [PC_W-1:0]      pc_d;
   logic [INSTR_W-1:0]   ir_q;
   logic [STEP_W-1:0]    steps_q;
   logic [STEP_W-1:0]    steps_d;
   logic [3:0]           flags_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 error_q;

   logic [2:0]           ir_op;
   logic [3:0]           ir_mask;
   logic [REG_W-1:0]     ir_data;
   logic                 ex_alu;
   logic                 br_taken;
   logic [REG_W-1:0]     rf_rdata0;
   logic [REG_W-1:0]     rf_rdata1;

   assign ir_op   = ir_q[OP_MSB:OP_LSB];
   assign ir_mask = ir_q[MASK_MSB:MASK_LSB];
   assign ir_data = ir_q[DATA_MSB:0];

   alu_seq_regfile u_regfile (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_we     (ex_alu),
      .i_waddr  (ir_q[RD_MSB:RD_LSB]),
      .i_wdata  (i_result),
      .i_raddr0 (ir_q[RS_MSB:RS_LSB]),
      .i_raddr1 (ir_q[RS2_MSB:0]),
      .i_raddr2 (i_rsel),
      .o_rdata0 (rf_rdata0),
      .o_rdata1 (rf_rdata1),
      .o_rdata2 (o_rdata)
   );

   always_comb begin
      ex_alu   = (state_q == ST_EXEC) && (ir_op != OP_BR) && (ir_op != OP_HALT);
      o_arg0   = '0;
      o_arg1   = '0;
      o_oper   = OP_ADD;
      o_data   = '0;
      o_imm    = 1'b0;
      // Outside an ALU execute the ALU is parked on a zero-operand add.
      if (ex_alu) begin
         o_arg0 = rf_rdata0;
         o_arg1 = rf_rdata1;
         o_oper = ir_op;
         o_data = ir_data;
         o_imm  = ir_q[IMM_BIT];
      end
      br_taken = (ir_mask == 4'b0000) || ((ir_mask & flags_q) != 4'b0000);
      if ((ir_op == OP_BR) && br_taken) begin
         pc_d = PC_W'(ir_data);
      end else begin
         pc_d = pc_q + PC_W'(1);
      end
      steps_d = steps_q + STEP_W'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         steps_q <= '0;
         flags_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // A start coinciding with the done pulse waits one cycle.
               if (i_start && !done_q) begin
                  state_q <= ST_FETCH;
                  pc_q    <= '0;
                  steps_q <= '0;
                  error_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_FETCH: begin
               state_q <= ST_DECODE;
            end
            ST_DECODE: begin
               ir_q    <= i_instr;
               state_q <= ST_EXEC;
            end
            ST_EXEC: begin
               if (ir_op == OP_HALT) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  if (ex_alu) begin
                     flags_q <= i_flag;
                  end
                  pc_q    <= pc_d;
                  steps_q <= steps_d;
                  if (steps_d == STEP_W'(MAX_STEPS)) begin
                     done_q  <= 1'b1;
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     state_q <= ST_FETCH;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_pc    = pc_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_error = error_q;
   assign o_flags = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_seq_ctrl : directed program bench with a behavioural 6-bit ALU|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_seq_ctrl;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, SHF = 3'd2, AND_ = 3'd3;
   localparam logic [2:0] OR_ = 3'd4, XOR_ = 3'd5, BR = 3'd6, HLT = 3'd7;
   localparam int NVEC = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, error;
   logic [5:0]  pc;
   logic [13:0] instr = '0;
   logic [5:0]  arg0, arg1, data, result;
   logic [2:0]  oper;
   logic        imm;
   logic [3:0]  flag, flags;
   logic [1:0]  rsel = 2'd0;
   logic [5:0]  rdata;

   logic [13:0] rom [64];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0][13:0] prog;
      logic [3:0][5:0]  regs;
      logic [3:0]       flg;
      int               cycles;
      logic             err;
   } vec_t;

   vec_t vecs [NVEC];

   alu_seq_ctrl #(.PC_W(6), .MAX_STEPS(63)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .o_busy(busy), .o_done(done), .o_error(error),
      .o_pc(pc), .i_instr(instr),
      .o_arg0(arg0), .o_arg1(arg1), .o_oper(oper), .o_data(data), .o_imm(imm),
      .i_result(result), .i_flag(flag),
      .i_rsel(rsel), .o_rdata(rdata), .o_flags(flags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) instr <= rom[pc];

   // Reference ALU: signed shift amount, positive shifts left.
   logic [5:0] alu_b, alu_r;
   logic       alu_o;
   int         sh;
   always_comb begin
      alu_b = imm ? data : arg1;
      alu_r = '0;
      alu_o = 1'b0;
      sh    = $signed(alu_b);
      case (oper)
         ADD: begin
            alu_r = arg0 + alu_b;
            alu_o = (arg0[5] == alu_b[5]) && (alu_r[5] != arg0[5]);
         end
         SUB: begin
            alu_r = arg0 - alu_b;
            alu_o = (arg0[5] != alu_b[5]) && (alu_r[5] != arg0[5]);
         end
         SHF:  alu_r = (sh >= 0) ? ($signed(arg0) <<< sh) : ($signed(arg0) >>> (-sh));
         AND_: alu_r = arg0 & alu_b;
         OR_:  alu_r = arg0 | alu_b;
         XOR_: alu_r = arg0 ^ alu_b;
         default: alu_r = '0;
      endcase
      result = alu_r;
      flag   = {alu_o, (alu_r == 6'd0), (!alu_r[5] && alu_r != 6'd0), alu_r[5]};
   end

   function automatic logic [13:0] enc(logic [2:0] op, logic im, logic [1:0] rd,
                                       logic [1:0] rs, logic [5:0] d);
      return {op, im, rd, rs, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic load(input int v);
      for (int a = 0; a < 64; a++) rom[a] = enc(HLT, 1'b0, 2'd0, 2'd0, 6'd0);
      for (int k = 0; k < 8; k++) rom[k] = vecs[v].prog[k];
   endtask

   task automatic run_prog(output int cyc);
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      check("busy_after_start", 32'(busy), 32'd1);
      while (!done && cyc < 400) begin
         tick();
         cyc++;
      end
      check("done_seen", 32'(done), 32'd1);
   endtask

   task automatic check_regs(string tag, logic [3:0][5:0] exp);
      for (int r = 0; r < 4; r++) begin
         rsel = 2'(r);
         #1;
         check($sformatf("%s_r%0d", tag, r), 32'(rdata), 32'(exp[r]));
      end
   endtask

   initial begin
      int cyc;
      int ndone;

      for (int v = 0; v < NVEC; v++) begin
         for (int k = 0; k < 8; k++) vecs[v].prog[k] = enc(HLT, 1'b0, 2'd0, 2'd0, 6'd0);
         vecs[v].err = 1'b0;
      end
      // 31 + 1 overflows to -32 with N and O set
      vecs[0].prog[0] = enc(ADD, 1'b1, 2'd0, 2'd0, 6'd31);
      vecs[0].prog[1] = enc(ADD, 1'b1, 2'd1, 2'd0, 6'd1);
      vecs[0].regs = {6'd0, 6'd0, 6'h20, 6'd31}; vecs[0].flg = 4'b1001; vecs[0].cycles = 10;
      // branch on N taken, skipping the add at address 2
      vecs[1].prog[0] = enc(SUB, 1'b1, 2'd0, 2'd0, 6'd5);
      vecs[1].prog[1] = enc(BR, 1'b0, 2'b00, 2'b01, 6'd3);
      vecs[1].prog[2] = enc(ADD, 1'b1, 2'd1, 2'd1, 6'd7);
      vecs[1].regs = {6'd0, 6'd0, 6'd0, 6'h3B}; vecs[1].flg = 4'b0001; vecs[1].cycles = 10;
      vecs[2].prog[0] = enc(ADD, 1'b1, 2'd0, 2'd0, 6'd3);
      vecs[2].prog[1] = enc(SHF, 1'b1, 2'd1, 2'd0, 6'h3F);
      vecs[2].regs = {6'd0, 6'd0, 6'd1, 6'd3}; vecs[2].flg = 4'b0010; vecs[2].cycles = 10;
      vecs[3].prog[0] = enc(ADD, 1'b1, 2'd0, 2'd0, 6'd3);
      vecs[3].prog[1] = enc(SHF, 1'b1, 2'd1, 2'd0, 6'd2);
      vecs[3].regs = {6'd0, 6'd0, 6'd12, 6'd3}; vecs[3].flg = 4'b0010; vecs[3].cycles = 10;
      // register-mode XOR r0 = r2 ^ r3
      vecs[4].prog[0] = enc(ADD, 1'b1, 2'd2, 2'd2, 6'd12);
      vecs[4].prog[1] = enc(ADD, 1'b1, 2'd3, 2'd3, 6'd10);
      vecs[4].prog[2] = enc(XOR_, 1'b0, 2'd0, 2'd2, 6'd3);
      vecs[4].regs = {6'd10, 6'd12, 6'd0, 6'd6}; vecs[4].flg = 4'b0010; vecs[4].cycles = 13;
      // branch on N not taken after a positive result
      vecs[5].prog[0] = enc(ADD, 1'b1, 2'd0, 2'd0, 6'd5);
      vecs[5].prog[1] = enc(BR, 1'b0, 2'b00, 2'b01, 6'd3);
      vecs[5].prog[2] = enc(ADD, 1'b1, 2'd1, 2'd1, 6'd7);
      vecs[5].regs = {6'd0, 6'd0, 6'd7, 6'd5}; vecs[5].flg = 4'b0010; vecs[5].cycles = 13;
      vecs[6].prog[0] = enc(ADD, 1'b1, 2'd0, 2'd0, 6'd12);
      vecs[6].prog[1] = enc(AND_, 1'b1, 2'd1, 2'd0, 6'd10);
      vecs[6].prog[2] = enc(OR_, 1'b1, 2'd2, 2'd0, 6'd3);
      vecs[6].prog[3] = enc(SUB, 1'b0, 2'd3, 2'd0, 6'd0);
      vecs[6].regs = {6'd0, 6'd15, 6'd8, 6'd12}; vecs[6].flg = 4'b0100; vecs[6].cycles = 16;
      // unconditional branch to itself trips the watchdog
      vecs[7].prog[0] = enc(BR, 1'b0, 2'b00, 2'b00, 6'd0);
      vecs[7].regs = '0; vecs[7].flg = 4'b0000; vecs[7].cycles = 190; vecs[7].err = 1'b1;

      load(0);
      do_reset();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_alu", 32'({arg0, arg1, oper, data, imm}), 32'd0);

      for (int v = 0; v < NVEC; v++) begin
         load(v);
         do_reset();
         run_prog(cyc);
         check($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vecs[v].cycles));
         check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].err));
         check($sformatf("v%0d_flags", v), 32'(flags), 32'(vecs[v].flg));
         check_regs($sformatf("v%0d", v), vecs[v].regs);
         tick();
         check($sformatf("v%0d_done_drop", v), 32'(done), 32'd0);
      end

      // error from the watchdog run clears on the next accepted start
      load(0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("err_clear_on_start", 32'(error), 32'd0);
      while (!done && busy) tick();

      // start pulsed while busy is ignored
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      for (int i = 0; i < 3; i++) begin tick(); cyc++; end
      start = 1'b1;
      tick(); cyc++;
      start = 1'b0;
      while (!done && cyc < 400) begin tick(); cyc++; end
      check("busy_start_cycles", 32'(cyc), 32'd10);
      check_regs("busy_start", vecs[0].regs);

      // start during the done pulse waits one cycle
      start = 1'b1;
      tick();
      check("start_on_done_ignored", 32'(busy), 32'd0);
      tick();
      check("start_after_done_taken", 32'(busy), 32'd1);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 400) begin tick(); cyc++; end
      check("restart_cycles", 32'(cyc), 32'd10);

      // reset during EXEC of the first instruction
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("exec_data_before_rst", 32'(data), 32'd31);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check_regs("midrst", '0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) ndone++;
         tick();
      end
      check("midrst_no_done", 32'(ndone), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Program sequencer for the 6-bit signed ALU. Fetches 14-bit instructions from an external synchronous program ROM and decodes them.
- Owns a 4-entry x 6-bit register file and a 4-bit flag register. Drives the ALU operand/opcode/immediate ports and writes the ALU result and flags back.
- Supports conditional branches on the stored flags, a halt instruction and a step-limit watchdog.
- Sits between the communication unit's command logic (start/done handshake) and the ALU datapath.

Parameters:
- PC_W, 6, program counter / ROM address width.
- MAX_STEPS, 63, executed-instruction limit before abort with error.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  start program at address 0; honoured only in IDLE
- o_busy  out  1  high in FETCH/DECODE/EXEC
- o_done  out  1  one-cycle pulse on halt or abort
- o_error  out  1  set with o_done if aborted by the watchdog; cleared on next accepted start
- o_pc  out  PC_W  ROM address
- i_instr  in  14  ROM data, valid the cycle after o_pc is presented
- o_arg0  out  6  to ALU i_arg0
- o_arg1  out  6  to ALU i_arg1
- o_oper  out  3  to ALU i_oper
- o_data  out  6  to ALU i_data
- o_imm  out  1  to ALU i_imm
- i_result  in  6  from ALU o_result
- i_flag  in  4  from ALU o_flag: [0]N, [1]P, [2]Z, [3]O
- i_rsel  in  2  register readout select
- o_rdata  out  6  combinational readout of reg[i_rsel]
- o_flags  out  4  stored flag register

Behaviour:
- Reset: state IDLE; pc=0; regs=0; flags=0; step count=0; o_busy=0, o_done=0, o_error=0. Every ALU drive output is 0. Reset mid-program aborts immediately without a done pulse.
- Instruction format:
  - [13:11] op: 000–101 are ALU ops, passed through to o_oper; 110 = BR; 111 = HALT.
  - [10] imm.
  - [9:8] rd.
  - [7:6] rs.
  - [5:0] data: the immediate, or rs2 in [1:0] when imm=0.
- States:
  - IDLE: on i_start, go to FETCH with pc=0, steps=0, o_error=0.
  - FETCH: o_pc=pc; go to DECODE.
  - DECODE: latch i_instr into the instruction register; go to EXEC.
  - EXEC, ALU op:
    - o_arg0=reg[rs], o_oper=op, o_imm=imm, o_data=data.
    - o_arg1=reg[data[1:0]]; only meaningful when imm=0.
    - At the end of the cycle: reg[rd] <= i_result, flags <= i_flag, pc <= pc+1.
  - EXEC, BR:
    - Mask is [9:6]. Taken if (mask & flags) != 0; then pc <= data[PC_W-1:0], else pc+1.
    - mask=0000 is an unconditional branch.
    - Flags are unchanged.
  - EXEC, HALT: pulse o_done, go to IDLE; pc and regs are held.
  - EXEC, other ops: steps <= steps+1. If steps reaches MAX_STEPS, pulse o_done, set o_error and go to IDLE instead of FETCH. Otherwise go to FETCH.
- Latency: 3 cycles per instruction. o_done asserts the cycle after the HALT instruction's EXEC.
- Outside EXEC, o_oper=000, o_imm=0 and the args are 0, so the ALU sees a benign add.
- pc wraps modulo 2^PC_W. Fall-through from the last address to 0 is legal.
- A register write and an o_rdata read of the same register in the same cycle return the old value.
- i_start while busy is ignored. i_start on the same cycle as o_done is ignored; it is accepted the following cycle.
- BR target bits above PC_W are ignored.

Decomposition:
- Package alu_seq_pkg:
  - state enum (IDLE, FETCH, DECODE, EXEC);
  - opcode constants OP_ADD..OP_XOR, OP_BR, OP_HALT;
  - instruction field bit positions;
  - flag index constants FLG_N, FLG_P, FLG_Z, FLG_O.
- Sub-module alu_seq_regfile: 4x6 registers, two combinational read ports plus the debug port, one synchronous write port, synchronous reset clear.
- The ALU itself stays outside, connected at the top level.

Test Plan:
- Program: ADD r0,r0,#31; ADD r1,r0,#1; HALT.
  - Required: r0=31; r1=-32 (6'b100000); flags=4'b1001; o_done 10 cycles after start; o_error=0.
- Program: SUB r0,r0,#5; BR mask=N to addr 3; ADD r1,r1,#7 (skipped); HALT.
  - Required: r0=-5, r1=0, branch taken.
- Shift: r0=#3, then op 010 r1,r0,#-1.
  - Required: r1=1. Repeat with #2: r1=12.
- Register mode:
  - Setup: r2=#12, r3=#10.
  - Op: XOR r0,r2,rs2=r3 with imm=0.
  - Required: r0=6; flags P set.
- Watchdog: BR mask=0000 to its own address with MAX_STEPS=63.
  - Required: o_done with o_error=1 after 63 executed instructions.
- Control edge cases: i_rst asserted during EXEC, and i_start pulsed while busy.
  - On reset: next cycle IDLE, regs=0, no o_done.
  - On start while busy: ignored, program result unchanged.
